// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_reader register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;
  localparam int DEPTH          = 2 ** REGFILE_ADDR_W;
  localparam int ZERO_REG       = 0;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every register address once, then
// raises ready. All outputs come straight from flops.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  state_t            state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              clr_en_r;
  logic              ready_r;

  // Sweep FSM: clear one entry per cycle in INIT, park in READY until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= INIT;
      idx_r    <= {ADDR_W{1'b0}};
      clr_en_r <= 1'b1;
      ready_r  <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          if (idx_r == LAST_IDX) begin
            state_r  <= READY;
            clr_en_r <= 1'b0;
            ready_r  <= 1'b1;
          end else begin
            idx_r <= idx_r + ADDR_W'(1);
          end
        end
        READY: begin
          clr_en_r <= 1'b0;
          ready_r  <= 1'b1;
        end
        default: begin
          state_r  <= INIT;
          idx_r    <= {ADDR_W{1'b0}};
          clr_en_r <= 1'b1;
          ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en   = clr_en_r;
  assign clr_addr = idx_r;
  assign ready    = ready_r;

endmodule

// File: rtl/regfile_reader.sv
// Register file: one write port, two registered read ports with a shared
// valid strobe, and a post-reset clear sweep gating both ports.
// Optional macro REGFILE_BYPASS_EN: same-cycle write/read of one nonzero
// address returns the new write data (write-first); otherwise read-first.
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid,
  output logic              ready
);

  localparam int                NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_r [NUM_REGS];
  logic [DATA_W-1:0] rdata1_r;
  logic [DATA_W-1:0] rdata2_r;
  logic              rvalid_r;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic              clr_en_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              ready_s;

  regfile_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (clr_en_s),
    .clr_addr (clr_addr_s),
    .ready    (ready_s)
  );

  // Array write port: clear sweep owns it during INIT, core writes after.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (clr_en_s) begin
        mem_r[clr_addr_s] <= {DATA_W{1'b0}};
      end else if (ready_s && we && (waddr != ZERO_ADDR)) begin
        mem_r[waddr] <= wdata;
      end
    end
  end

  // Read data selection: register 0 reads as zero, optional write bypass.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    rd2_s = {DATA_W{1'b0}};
    if (raddr1 == ZERO_ADDR) begin
      rd1_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (we && (raddr1 == waddr)) begin
      rd1_s = wdata;
`endif
    end else begin
      rd1_s = mem_r[raddr1];
    end
    if (raddr2 == ZERO_ADDR) begin
      rd2_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (we && (raddr2 == waddr)) begin
      rd2_s = wdata;
`endif
    end else begin
      rd2_s = mem_r[raddr2];
    end
  end

  // Registered read ports: capture on re once ready, otherwise hold data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata1_r <= {DATA_W{1'b0}};
      rdata2_r <= {DATA_W{1'b0}};
      rvalid_r <= 1'b0;
    end else if (ready_s && re) begin
      rdata1_r <= rd1_s;
      rdata2_r <= rd2_s;
      rvalid_r <= 1'b1;
    end else begin
      rvalid_r <= 1'b0;
    end
  end

  assign rdata1 = rdata1_r;
  assign rdata2 = rdata2_r;
  assign rvalid = rvalid_r;
  assign ready  = ready_s;

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever rvalid is presented.
module tb_regfile_reader;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        rvalid;
  logic        ready;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  regfile_reader dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .rvalid (rvalid),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    re = 1'b1; raddr1 = a1; raddr2 = a2;
    sb_q.push_back({e1, e2});
    step();
    re = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  // Monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (rst === 1'b1 && rvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_rvalid", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("rdata1", rdata1, e[63:32]);
        check("rdata2", rdata2, e[31:0]);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    re = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;

    // Reset state
    repeat (3) step();
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_ready",  {31'd0, ready},  32'd0);

    // First sweep, then dirty every register
    rst = 1'b1;
    wait_ready(n);
    check("ready_lat_first", n, 32'd32);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3 + 1));

    // Reset with re held high: no rvalid during reset/INIT
    re = 1'b1; raddr1 = 5'd3; raddr2 = 5'd4;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    wait_ready(n);
    re = 1'b0;
    check("ready_lat_sweep", n, 32'd32);
    check("init_rdata1_hold", rdata1, 32'd0);

    // Every register reads zero after the sweep (back-to-back reads)
    for (int i = 0; i < 16; i++) rd(5'(i), 5'(i + 16), 32'd0, 32'd0);
    step();

    // Basic write then read, rvalid is a one-cycle strobe
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    step();
    check("rvalid_strobe", {31'd0, rvalid}, 32'd0);

    // Register 0 protection, including a same-cycle read of reg 0
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0, 32'd0, 32'd0);
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    rd(5'd0, 5'd5, 32'd0, 32'hDEADBEEF);

    // Same-cycle write/read hazard, port 1 then port 2
    wr(5'd7, 32'h1);
    we = 1'b1; waddr = 5'd7; wdata = 32'h2;
    rd(5'd7, 5'd5, BYP ? 32'h2 : 32'h1, 32'hDEADBEEF);
    rd(5'd7, 5'd7, 32'h2, 32'h2);
    wr(5'd8, 32'h3);
    we = 1'b1; waddr = 5'd8; wdata = 32'h4;
    rd(5'd7, 5'd8, 32'h2, BYP ? 32'h4 : 32'h3);
    rd(5'd8, 5'd8, 32'h4, 32'h4);

    // Back-to-back reads then hold
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'(i + 9));
    for (int i = 1; i <= 4; i++) rd(5'(i), 5'd7, 32'(i + 9), 32'h2);
    step();
    check("hold_rvalid", {31'd0, rvalid}, 32'd0);
    check("hold_rdata1", rdata1, 32'd13);
    step();
    check("hold_rdata1_2", rdata1, 32'd13);

    // Mid-sweep reset restarts the sweep from index 0
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (16) step();
    check("mid_sweep_not_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    wait_ready(n);
    check("ready_lat_restart", n, 32'd32);
    rd(5'd5, 5'd13, 32'd0, 32'd0);

    // Drain scoreboard
    repeat (3) step();
    check("sb_drain", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
Name: regfile_reader

Overview:
- Register file for the KGPminiRISC datapath, read by decode/execute stages.
- Holds architectural register state.
- One synchronous write port (writer side) and two registered read ports (reader side), with a valid strobe on the read data.
- After reset, a clear sweep zeroes every register one per cycle, then asserts ready; the core stalls until ready.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers (32).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled only on posedge clk.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- re  input  1  read request for both read ports.
- raddr1  input  ADDR_W  read port 1 address.
- raddr2  input  ADDR_W  read port 2 address.
- rdata1  output  DATA_W  read port 1 data, registered.
- rdata2  output  DATA_W  read port 2 data, registered.
- rvalid  output  1  one-cycle strobe: rdata1/rdata2 updated this cycle.
- ready  output  1  high once the clear sweep completes.

Behaviour:
- Reset: at a posedge with rst==0:
  - state<=INIT, idx<=0.
  - rdata1<=0, rdata2<=0, rvalid<=0, ready<=0.
  - Array contents are not touched by reset itself.
- FSM states: INIT, READY.
- INIT:
  - Each posedge with rst==1: mem[idx]<=0, idx<=idx+1.
  - At the edge where idx==DEPTH-1: clear the last entry, state<=READY, ready<=1.
  - ready is therefore first high after exactly DEPTH (32) posedges with rst==1.
  - we and re are ignored; rvalid stays 0; rdata holds 0.
- Reset mid-sweep: the sweep restarts at idx 0 with ready=0.
- READY: remains until the next reset; no other exit.
- Write (READY only): at posedge, if we==1 and waddr!=0, mem[waddr]<=wdata. Writes to register 0 are dropped.
- Read (READY only):
  - If re==1 at posedge: rdata1<=rd(raddr1), rdata2<=rd(raddr2), rvalid<=1.
  - Read latency is one cycle.
  - If re==0: rvalid<=0 and rdata1/rdata2 hold their previous values.
- rd(0) always returns 0, regardless of array contents.
- Back-to-back reads: re held high gives rvalid high every cycle, with fresh data each cycle.
- Simultaneous read and write to the same nonzero address in one cycle: see Optional Feature.
- Both read ports may address the same register; both return identical data.
- Width rules:
  - No arithmetic on data.
  - idx is ADDR_W bits.
  - DEPTH-1 comparison at full ADDR_W width; no wrap is used, because the transition occurs at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write and read to the same nonzero address returns the new wdata on that read port (write-first). Port 1 and port 2 are checked independently.
- Undefined: the read returns the old array value (read-first); the new value is visible from the next read on.
- Register 0 returns 0 in both builds.

Decomposition:
- Package regfile_pkg:
  - DATA_W and ADDR_W defaults.
  - DEPTH constant.
  - State typedef: INIT=1'b0, READY=1'b1.
  - ZERO_REG constant (0).
- Sub-module regfile_init_seq:
  - Contains the idx counter and the INIT/READY FSM.
  - Outputs clr_en, clr_addr, ready.
  - The top level muxes the clear path onto the array write port.

Test Plan:
- Reset sweep: write nonzero to regs pre-reset, hold rst=0 for 3 cycles, release → ready rises after exactly 32 posedges; all reads return 0; rvalid stays 0 during INIT even with re=1.
- Write/read: we=1, waddr=5, wdata=32'hDEADBEEF; next cycle re=1, raddr1=5, raddr2=0 → one cycle later rdata1=32'hDEADBEEF, rdata2=0, rvalid=1 for one cycle.
- Reg 0 protection: we=1, waddr=0, wdata=32'hFFFFFFFF; then read raddr1=0 → rdata1=0.
- Same-cycle hazard: reg7=32'h1; same cycle we=1, waddr=7, wdata=32'h2, re=1, raddr1=7 → rdata1=32'h2 with REGFILE_BYPASS_EN, 32'h1 without; the following read gives 32'h2 in both builds.
- Hold and back-to-back: re high 4 cycles over raddr1=1..4 (preloaded 10..13) → rdata1=10,11,12,13 with rvalid high 4 cycles; re low next cycle → rvalid=0, rdata1 holds 13.
- Mid-sweep reset: assert rst=0 at sweep cycle 16, release → ready rises 32 cycles after release, not 16.
